mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the single synchronous-read instruction/data RAM between the CPU (requester 0) and a second master such as the program loader or debug port (requester 1). It accepts one request at a time and grants the winner by round-robin. It latches the winner's command, address and write data, then sequences the RAM access through a fixed read latency. Completion is signalled by a one-cycle acknowledge, with read data alongside. It sits between the masters' `mem_cmd`/`mem_addr` style outputs and the RAM.

## Interface
Parameters:
- ADDR_W, 9, memory address width
- DATA_W, 16, memory data width
- RD_LAT, 1, RAM read latency in cycles from address presented to `mem_dout` valid; legal 1..3

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- req0, req1  input  1 each  request valid from requester 0 / 1
- cmd0, cmd1  input  2 each  command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved
- addr0, addr1  input  ADDR_W each  request address
- wdata0, wdata1  input  DATA_W each  write data
- gnt0, gnt1  output  1 each  requester owns the memory (ACCESS through DONE)
- ack0, ack1  output  1 each  one-cycle completion pulse
- rdata  output  DATA_W  read data, valid when ack is high for a READ; held until next read capture
- busy  output  1  high in any state other than IDLE
- mem_addr  output  ADDR_W  RAM address
- mem_din  output  DATA_W  RAM write data
- mem_write  output  1  RAM write enable
- mem_read  output  1  RAM read strobe
- mem_dout  input  DATA_W  RAM read data

## Operation
- A request is valid when reqN=1 and cmdN is READ or WRITE. NONE and the reserved encoding are ignored and never granted.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE, with any valid request:
  - Select the winner and latch its cmd, addr and wdata into internal registers.
  - Go to ACCESS.
  - With no valid request, stay in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester indicated by the priority bit `prio` wins.
- ACCESS (exactly 1 cycle):
  - `mem_addr` and `mem_din` come from the latched registers.
  - For a WRITE, mem_write=1, and the next state is DONE.
  - For a READ, mem_read=1, the wait counter loads RD_LAT, and the next state is WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, `mem_dout` is captured into `rdata`, and the next state is DONE.
- DONE (1 cycle):
  - ackN=1 for the owner.
  - `prio` is set to the other requester, whether or not the other requester is requesting.
  - The next state is IDLE.
  - Requests are not sampled in DONE.
- `gntN` is high in ACCESS, WAIT and DONE for the owner, and is otherwise 0.
- Requester behaviour after grant:
  - Because request fields are latched, the requester need only hold them until its gnt rises.
  - Deasserting req after grant does not abort the access; ack still pulses.
- Outside ACCESS, `mem_write` and `mem_read` are 0. `mem_addr` and `mem_din` continue to show the latched values.
- The reserved cmd 2'b11 never reaches the RAM.

## Timing
- Reset values:
  - State is IDLE and `prio`=0, so requester 0 wins the first contention.
  - gnt0, gnt1, ack0, ack1, busy, mem_write and mem_read are 0.
  - rdata, mem_addr and mem_din are 0, as are all latched registers.
- Reset mid-operation: the transaction is abandoned, no ack is issued, and mem_write is 0 from the cycle after reset is sampled.
- Write latency: request sampled in IDLE at cycle T, ACCESS at T+1 (RAM written at end of T+1), ack at T+2.
- Read latency: IDLE at T, ACCESS at T+1, WAIT at T+2..T+1+RD_LAT, ack and rdata valid at T+2+RD_LAT.
- Throughput:
  - The next request can be sampled at the cycle after DONE.
  - The minimum spacing is 3 cycles per WRITE and 3+RD_LAT cycles per READ.
- Simultaneous requests in IDLE: exactly one is granted. The loser must keep req asserted and is served next, since `prio` has flipped.
- A requester that keeps requesting back-to-back while the other also requests alternates strictly. Starvation is impossible.

## Test plan
- Single write: reset, then req0=1, cmd0=WRITE, addr0=9'h005, wdata0=16'hABCD. Required: gnt0 at T+1; mem_write=1, mem_addr=5, mem_din=ABCD at T+1 only; ack0 at T+2; busy low at T+3.
- Read-back, RD_LAT=1, RAM preloaded [5]=16'hABCD: req1 READ addr 5. Required: mem_read at T+1, ack1 at T+3, rdata=16'hABCD at T+3 and held afterwards.
- Contention: req0 and req1 both held with WRITE to addresses 1 and 2 after reset. Required: requester 0 is served first (ack0), then requester 1 (ack1), then 0, strictly alternating. No cycle has gnt0 and gnt1 both high.
- Fields latched: req0 READ addr 7, then change addr0 to 9 and drop req0 in the cycle after gnt0 rises. Required: mem_addr stays 7 and ack0 still pulses.
- Ignored commands: req0=1 with cmd0=NONE, and separately with cmd0=2'b11, for 10 cycles. Required: busy, gnt0, mem_write and mem_read all stay 0.
- Reset mid-read, RD_LAT=3: assert reset in the first WAIT cycle. Required: state returns to IDLE, no ack is issued, and rdata=0. A following req1 READ wins despite `prio` having been 0 only if req0 is idle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between two masters.
// Accepts a single request at a time, picks the winner round-robin, latches
// its command/address/write data, then drives one RAM access through a
// fixed read latency and returns a one-cycle acknowledge.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req0/1, cmd0/1        request valid and command (01 READ, 10 WRITE)
//   addr0/1, wdata0/1     request address and write data
//   gnt0/1                owner of the memory, ACCESS through DONE
//   ack0/1                one-cycle completion pulse
//   rdata                 read data, valid with ack of a READ, then held
//   busy                  arbiter not idle
//   mem_addr, mem_din     RAM address / write data (latched request fields)
//   mem_write, mem_read   RAM strobes, only ever high in ACCESS
//   mem_dout              RAM read data
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        cmd0,
  input  logic [1:0]        cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] LAT       = 2'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                prio;
  logic [1:0]          cmd_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic [1:0]          cnt;
  logic                valid0;
  logic                valid1;
  logic                win;

  // NONE and the reserved encoding never count as a request.
  assign valid0 = req0 && (cmd0 == CMD_READ || cmd0 == CMD_WRITE);
  assign valid1 = req1 && (cmd1 == CMD_READ || cmd1 == CMD_WRITE);

  // Contention is settled by prio; a lone valid requester always wins.
  assign win = (valid0 && valid1) ? prio : valid1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (valid0 || valid1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = (cmd_l == CMD_WRITE) ? S_DONE : S_WAIT;
      S_WAIT:   if (cnt == 2'd1) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      cmd_l   <= '0;
      addr_l  <= '0;
      wdata_l <= '0;
      cnt     <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (valid0 || valid1) begin
            owner <= win;
            if (win) begin
              cmd_l   <= cmd1;
              addr_l  <= addr1;
              wdata_l <= wdata1;
            end else begin
              cmd_l   <= cmd0;
              addr_l  <= addr0;
              wdata_l <= wdata0;
            end
          end
        end
        S_ACCESS: begin
          if (cmd_l == CMD_READ) cnt <= LAT;
        end
        S_WAIT: begin
          cnt <= cnt - 2'd1;
          // Last wait cycle: RAM output now reflects the presented address.
          if (cnt == 2'd1) rdata <= mem_dout;
        end
        S_DONE: begin
          // Hand priority to the other side whether or not it is asking.
          prio <= ~owner;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign gnt0      = busy && !owner;
  assign gnt1      = busy && owner;
  assign ack0      = (state == S_DONE) && !owner;
  assign ack1      = (state == S_DONE) && owner;
  assign mem_addr  = addr_l;
  assign mem_din   = wdata_l;
  assign mem_write = (state == S_ACCESS) && (cmd_l == CMD_WRITE);
  assign mem_read  = (state == S_ACCESS) && (cmd_l == CMD_READ);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a table of single transactions plus hand-written
// contention, latching, ignored-command and reset-mid-read sequences, checked
// through a queue of expected accesses/acknowledges.
module tb_mem_arbiter;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, busy, mem_write, mem_read;
  logic [15:0] rdata, mem_din, mem_dout;
  logic [8:0]  mem_addr;

  // Second instance with RD_LAT=3 for the reset-mid-read sequence.
  logic        reset_b;
  logic        req0_b, req1_b;
  logic [1:0]  cmd0_b, cmd1_b;
  logic [8:0]  addr0_b, addr1_b;
  logic [15:0] wdata0_b, wdata1_b;
  logic        gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b, mem_write_b, mem_read_b;
  logic [15:0] rdata_b, mem_din_b, mem_dout_b;
  logic [8:0]  mem_addr_b;

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_write(mem_write), .mem_read(mem_read), .mem_dout(mem_dout)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .req1(req1_b), .cmd0(cmd0_b), .cmd1(cmd1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
    .rdata(rdata_b), .busy(busy_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b),
    .mem_write(mem_write_b), .mem_read(mem_read_b), .mem_dout(mem_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one cycle read latency.
  logic [15:0] ram [512];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  typedef struct {
    bit          port;
    bit          rd;
    logic [8:0]  addr;
    logic [15:0] data;
    int          acc_cyc;
    int          ack_cyc;
  } exp_t;

  typedef struct {
    bit          port;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and check accesses/acks against the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
    if (mem_write || mem_read) begin
      if (sbq.size() == 0) begin
        check("unexpected_access", 32'({mem_write, mem_read}), 32'd0);
      end else begin
        e = sbq[0];
        check("access_cycle", 32'(cyc), 32'(e.acc_cyc));
        check("access_kind", 32'({mem_write, mem_read}), e.rd ? 32'd1 : 32'd2);
        check("access_addr", 32'(mem_addr), 32'(e.addr));
        check("access_gnt", 32'({gnt1, gnt0}), e.port ? 32'd2 : 32'd1);
        if (!e.rd) check("access_din", 32'(mem_din), 32'(e.data));
      end
    end
    if (ack0 || ack1) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 32'({ack1, ack0}), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        check("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
        if (e.rd) check("ack_rdata", 32'(rdata), 32'(e.data));
      end
    end
  endtask

  task automatic drive(input bit port, input bit req, input logic [1:0] cmd,
                       input logic [8:0] addr, input logic [15:0] wdata);
    if (port) begin
      req1 = req; cmd1 = cmd; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = req; cmd0 = cmd; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      check("ack_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic push(input bit port, input bit rd, input logic [8:0] addr,
                      input logic [15:0] data, input int t0);
    exp_t e;
    e.port = port; e.rd = rd; e.addr = addr; e.data = data;
    e.acc_cyc = t0 + 1;
    e.ack_cyc = rd ? t0 + 3 : t0 + 2;
    sbq.push_back(e);
  endtask

  initial begin
    int t0;
    vecs[0] = '{1'b0, WR, 9'h005, 16'hABCD, 16'h0000};
    vecs[1] = '{1'b1, RD, 9'h005, 16'h0000, 16'hABCD};
    vecs[2] = '{1'b1, WR, 9'h1FF, 16'h8001, 16'h0000};
    vecs[3] = '{1'b0, RD, 9'h1FF, 16'h0000, 16'h8001};
    vecs[4] = '{1'b0, WR, 9'h000, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, RD, 9'h000, 16'h0000, 16'hFFFF};
    vecs[6] = '{1'b1, WR, 9'h007, 16'h7777, 16'h0000};
    vecs[7] = '{1'b0, RD, 9'h002, 16'h0000, 16'h2222};

    reset = 1'b1; reset_b = 1'b1;
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    drive(1'b1, 1'b0, 2'b00, '0, '0);
    req0_b = 0; req1_b = 0; cmd0_b = 0; cmd1_b = 0;
    addr0_b = 0; addr1_b = 0; wdata0_b = 0; wdata1_b = 0;
    mem_dout_b = 16'h1234;
    repeat (3) tick();
    reset = 1'b0; reset_b = 1'b0;
    tick();

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_ack", 32'({ack1, ack0}), 32'd0);
    check("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);

    // Contention from reset: 0 first, then strict alternation.
    t0 = cyc;
    drive(1'b0, 1'b1, WR, 9'h001, 16'h1111);
    drive(1'b1, 1'b1, WR, 9'h002, 16'h2222);
    push(1'b0, 1'b0, 9'h001, 16'h1111, t0);
    push(1'b1, 1'b0, 9'h002, 16'h2222, t0 + 3);
    push(1'b0, 1'b0, 9'h001, 16'h1111, t0 + 6);
    push(1'b1, 1'b0, 9'h002, 16'h2222, t0 + 9);
    drain(40);
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    drive(1'b1, 1'b0, 2'b00, '0, '0);

    // Table of single transactions.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      t0 = cyc;
      drive(vecs[i].port, 1'b1, vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      push(vecs[i].port, vecs[i].cmd == RD, vecs[i].addr,
           (vecs[i].cmd == RD) ? vecs[i].exp_rdata : vecs[i].wdata, t0);
      tick();
      drive(vecs[i].port, 1'b0, 2'b00, '0, '0);
      drain(20);
      tick();
      check("busy_after_ack", 32'(busy), 32'd0);
    end

    // Fields latched: change addr and drop req right after the grant.
    wait_idle();
    t0 = cyc;
    drive(1'b0, 1'b1, RD, 9'h007, 16'h0000);
    push(1'b0, 1'b1, 9'h007, 16'h7777, t0);
    tick();
    check("latch_gnt0", 32'(gnt0), 32'd1);
    addr0 = 9'h009; req0 = 1'b0;
    drain(20);
    check("latch_mem_addr", 32'(mem_addr), 32'h7);
    repeat (3) tick();
    check("rdata_held", 32'(rdata), 32'h7777);
    check("latch_mem_addr_held", 32'(mem_addr), 32'h7);

    // Ignored commands.
    drive(1'b0, 1'b1, 2'b00, 9'h003, 16'h5555);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ignore_none", 32'({busy, gnt0, mem_write, mem_read}), 32'd0);
    end
    cmd0 = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ignore_rsvd", 32'({busy, gnt0, mem_write, mem_read}), 32'd0);
    end
    drive(1'b0, 1'b0, 2'b00, '0, '0);

    // Reset in the first WAIT cycle of an RD_LAT=3 read.
    req1_b = 1'b1; cmd1_b = RD; addr1_b = 9'h003;
    tick();
    check("b_access_read", 32'({mem_read_b, mem_write_b, gnt1_b}), 32'h5);
    check("b_access_addr", 32'(mem_addr_b), 32'h3);
    req1_b = 1'b0; cmd1_b = 2'b00;
    tick();
    check("b_wait_busy", 32'({busy_b, mem_read_b}), 32'h2);
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    check("b_rst_busy", 32'({busy_b, gnt1_b}), 32'd0);
    check("b_rst_rdata", 32'(rdata_b), 32'd0);
    check("b_rst_din", 32'(mem_din_b), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b_no_ack", 32'({ack0_b, ack1_b, mem_write_b}), 32'd0);
    end
    req1_b = 1'b1; cmd1_b = RD; addr1_b = 9'h004;
    tick();
    check("b_gnt1", 32'({gnt0_b, gnt1_b}), 32'd1);
    req1_b = 1'b0; cmd1_b = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_ack_early", 32'({ack0_b, ack1_b}), 32'd0);
    end
    tick();
    check("b_ack1", 32'({ack0_b, ack1_b}), 32'd1);
    check("b_rdata", 32'(rdata_b), 32'h1234);
    tick();
    check("b_idle", 32'({busy_b, ack1_b}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
